// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the memory port arbiter and its neighbours:
// the fetch stage, the memory stage and the single-port synchronous memory.
// Ports:
//   halt                      - STOP executed, blocks new grants
//   if_req/if_addr            - fetch read request
//   if_grant/if_stall         - fetch ownership / stall
//   if_rvalid/if_rdata        - fetch read return
//   d_req/d_we/d_addr/d_wdata - memory-stage load/store request
//   d_grant/d_stall           - memory-stage ownership / stall
//   d_rvalid/d_rdata          - load return
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata - memory port
// Modports: slave = the arbiter, master = the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          halt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_grant;
  logic          if_stall;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_grant;
  logic          d_stall;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_grant, if_stall, if_rvalid, if_rdata,
           d_grant, d_stall, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_grant, if_stall, if_rvalid, if_rdata,
           d_grant, d_stall, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// the memory stage. Data accesses win by default; a starvation counter hands
// the port to fetch for one cycle after MAX_WAIT consecutive denied fetches.
// Read data comes back one cycle after the grant and is routed to the port
// that issued it, then held per port until that port's next return.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requests, grants, stalls, memory port)
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]    starve_cnt;
  logic          rd_if;
  logic          rd_d;
  logic [DW-1:0] hold_if;
  logic [DW-1:0] hold_d;

  logic          if_grant_c;
  logic          d_grant_c;
  logic          starve_hit;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          mem_re_c;
  logic          mem_we_c;

  assign starve_hit = (starve_cnt == MAX_W);

  // Reset is folded into the grant so nothing reaches the memory while the
  // block is held in reset, even though the requests are still live.
  always_comb begin
    if_grant_c = 1'b0;
    d_grant_c  = 1'b0;
    if (reset && !bus.halt) begin
      if (bus.if_req && (!bus.d_req || starve_hit)) begin
        if_grant_c = 1'b1;
      end else if (bus.d_req) begin
        d_grant_c = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    if (d_grant_c) begin
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
      mem_we_c    = bus.d_we;
      mem_re_c    = !bus.d_we;
    end else if (if_grant_c) begin
      mem_addr_c  = bus.if_addr;
      mem_re_c    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      rd_if      <= 1'b0;
      rd_d       <= 1'b0;
      hold_if    <= '0;
      hold_d     <= '0;
    end else begin
      rd_if <= if_grant_c;
      rd_d  <= d_grant_c && !bus.d_we;
      if (rd_if) hold_if <= bus.mem_rdata;
      if (rd_d)  hold_d  <= bus.mem_rdata;
      // halt freezes the count so fairness history survives a STOP.
      if (!bus.halt) begin
        if (if_grant_c || !bus.if_req) begin
          starve_cnt <= 4'd0;
        end else if (!starve_hit) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.if_grant  = if_grant_c;
  assign bus.d_grant   = d_grant_c;
  assign bus.if_stall  = bus.if_req && !if_grant_c;
  assign bus.d_stall   = bus.d_req && !d_grant_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.if_rvalid = rd_if;
  assign bus.d_rvalid  = rd_d;
  // Pass the memory straight through on the return cycle, otherwise show
  // the last value returned to that port.
  assign bus.if_rdata  = rd_if ? bus.mem_rdata : hold_if;
  assign bus.d_rdata   = rd_d  ? bus.mem_rdata : hold_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic [7:0] mem [256];

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic h, input logic ir, input logic [7:0] ia,
                       input logic dr, input logic we, input logic [7:0] da,
                       input logic [7:0] wd);
    bus.halt    = h;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = wd;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h30] = 8'h5A;
    mem[8'h40] = 8'hC3;
    bus.mem_rdata = 8'h00;
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h02, 8'h00);
    #2;
    chk("rst_if_grant", bus.if_grant, 0);
    chk("rst_d_grant", bus.d_grant, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b1;

    // fetch only
    cyc(); drive(0, 1, 8'h10, 0, 0, 0, 0); #1;
    chk("f_grant", bus.if_grant, 1);
    chk("f_mem_re", bus.mem_re, 1);
    chk("f_mem_addr", bus.mem_addr, 8'h10);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_if_stall", bus.if_stall, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("f_rvalid", bus.if_rvalid, 1);
    chk("f_rdata", bus.if_rdata, 8'hA5);
    chk("f_idle_addr", bus.mem_addr, 0);
    chk("f_idle_re", bus.mem_re, 0);
    cyc(); #1;
    chk("f_rvalid_off", bus.if_rvalid, 0);
    chk("f_rdata_hold", bus.if_rdata, 8'hA5);

    // contention with MAX_WAIT = 4
    for (int k = 0; k < 6; k++) begin
      cyc(); drive(0, 1, 8'h01, 1, 0, 8'h02, 0); #1;
      chk($sformatf("c%0d_starve", k), dut.starve_cnt, (k <= 4) ? k : 0);
      chk($sformatf("c%0d_if_grant", k), bus.if_grant, (k == 4) ? 1 : 0);
      chk($sformatf("c%0d_d_grant", k), bus.d_grant, (k == 4) ? 0 : 1);
      chk($sformatf("c%0d_if_stall", k), bus.if_stall, (k == 4) ? 0 : 1);
      chk($sformatf("c%0d_d_stall", k), bus.d_stall, (k == 4) ? 1 : 0);
      if (k > 0) begin
        chk($sformatf("c%0d_if_rvalid", k), bus.if_rvalid, (k == 5) ? 1 : 0);
        chk($sformatf("c%0d_d_rvalid", k), bus.d_rvalid, (k == 5) ? 0 : 1);
      end
      if (k == 5) chk("c5_if_rdata", bus.if_rdata, 8'h11);
      if (k == 1) chk("c1_d_rdata", bus.d_rdata, 8'h22);
    end
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("c_tail_d_rvalid", bus.d_rvalid, 1);
    chk("c_tail_d_rdata", bus.d_rdata, 8'h22);
    chk("c_tail_if_rdata", bus.if_rdata, 8'h11);

    // store
    cyc(); drive(0, 0, 0, 1, 1, 8'h20, 8'h3C); #1;
    chk("s_grant", bus.d_grant, 1);
    chk("s_mem_we", bus.mem_we, 1);
    chk("s_mem_re", bus.mem_re, 0);
    chk("s_mem_addr", bus.mem_addr, 8'h20);
    chk("s_mem_wdata", bus.mem_wdata, 8'h3C);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s_no_rvalid", bus.d_rvalid, 0);
    chk("s_d_rdata_hold", bus.d_rdata, 8'h22);
    cyc(); drive(0, 0, 0, 1, 0, 8'h20, 0); #1;
    chk("s_load_re", bus.mem_re, 1);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s_load_rvalid", bus.d_rvalid, 1);
    chk("s_load_rdata", bus.d_rdata, 8'h3C);

    // alternating reads
    cyc(); drive(0, 1, 8'h01, 0, 0, 0, 0); #1;
    chk("a_f_grant", bus.if_grant, 1);
    cyc(); drive(0, 0, 0, 1, 0, 8'h02, 0); #1;
    chk("a_d_grant", bus.d_grant, 1);
    chk("a1_if_rvalid", bus.if_rvalid, 1);
    chk("a1_if_rdata", bus.if_rdata, 8'h11);
    chk("a1_d_rvalid", bus.d_rvalid, 0);
    chk("a1_d_rdata", bus.d_rdata, 8'h3C);
    cyc(); drive(0, 1, 8'h01, 0, 0, 0, 0); #1;
    chk("a2_d_rvalid", bus.d_rvalid, 1);
    chk("a2_d_rdata", bus.d_rdata, 8'h22);
    chk("a2_if_rvalid", bus.if_rvalid, 0);
    chk("a2_if_rdata", bus.if_rdata, 8'h11);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("a3_if_rvalid", bus.if_rvalid, 1);
    chk("a3_d_rvalid", bus.d_rvalid, 0);
    chk("a3_d_rdata", bus.d_rdata, 8'h22);

    // halt after a fetch grant
    cyc(); drive(0, 1, 8'h30, 0, 0, 0, 0); #1;
    chk("h_f_grant", bus.if_grant, 1);
    cyc(); drive(1, 1, 8'h30, 1, 0, 8'h02, 0); #1;
    chk("h_if_rvalid", bus.if_rvalid, 1);
    chk("h_if_rdata", bus.if_rdata, 8'h5A);
    chk("h_if_grant", bus.if_grant, 0);
    chk("h_d_grant", bus.d_grant, 0);
    chk("h_if_stall", bus.if_stall, 1);
    chk("h_d_stall", bus.d_stall, 1);
    chk("h_mem_re", bus.mem_re, 0);
    cyc(); #1;
    chk("h2_if_rvalid", bus.if_rvalid, 0);
    chk("h2_d_rvalid", bus.d_rvalid, 0);
    chk("h2_starve", dut.starve_cnt, 0);

    // starvation count frozen by halt
    cyc(); drive(0, 1, 8'h01, 1, 0, 8'h02, 0); #1;
    chk("z0_d_grant", bus.d_grant, 1);
    cyc(); #1;
    chk("z1_starve", dut.starve_cnt, 1);
    cyc(); drive(1, 1, 8'h01, 1, 0, 8'h02, 0); #1;
    chk("z2_starve", dut.starve_cnt, 2);
    chk("z2_d_grant", bus.d_grant, 0);
    cyc(); #1;
    chk("z3_starve_frozen", dut.starve_cnt, 2);
    cyc(); drive(0, 1, 8'h01, 1, 0, 8'h02, 0); #1;
    chk("z4_starve_frozen", dut.starve_cnt, 2);
    chk("z4_d_grant", bus.d_grant, 1);

    // reset pulsed after a load grant
    cyc(); drive(0, 1, 8'h01, 1, 0, 8'h40, 0); #1;
    chk("r_starve", dut.starve_cnt, 3);
    chk("r_d_grant", bus.d_grant, 1);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("r_pre_d_rvalid", bus.d_rvalid, 1);
    chk("r_pre_d_rdata", bus.d_rdata, 8'hC3);
    chk("r_pre_starve", dut.starve_cnt, 4);
    reset = 1'b0;
    drive(0, 1, 8'h10, 1, 0, 8'h40, 0);
    #1;
    chk("r_d_rvalid", bus.d_rvalid, 0);
    chk("r_d_rdata", bus.d_rdata, 0);
    chk("r_if_rdata", bus.if_rdata, 0);
    chk("r_starve_clr", dut.starve_cnt, 0);
    chk("r_mem_re", bus.mem_re, 0);
    chk("r_mem_we", bus.mem_we, 0);
    chk("r_if_grant", bus.if_grant, 0);
    chk("r_d_grant_off", bus.d_grant, 0);
    cyc();
    reset = 1'b1;
    drive(0, 1, 8'h10, 0, 0, 0, 0); #1;
    chk("r_resume_grant", bus.if_grant, 1);
    chk("r_resume_addr", bus.mem_addr, 8'h10);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("r_resume_rvalid", bus.if_rvalid, 1);
    chk("r_resume_rdata", bus.if_rdata, 8'hA5);
    chk("r_resume_d_rvalid", bus.d_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
